// File: rtl/csi_rx_clk_supervisor_if.sv
`default_nettype none
// ============================================================================
// Module   : csi_rx_clk_supervisor_if
// Brief    : Control/status bundle between RX control logic and the clock
//            supervisor. Revision : 1.0 - initial release
// ============================================================================
interface csi_rx_clk_supervisor_if;
  logic        enable;
  logic        pll_lock;
  logic        phy_reset;
  logic        link_ready;
  logic        fault;
  logic        lock_lost;
  logic [3:0]  retry_count;
  logic [2:0]  state;
  logic [15:0] lock_loss_count;

  modport master (
    output enable, pll_lock,
    input  phy_reset, link_ready, fault, lock_lost, retry_count, state,
           lock_loss_count
  );

  modport slave (
    input  enable, pll_lock,
    output phy_reset, link_ready, fault, lock_lost, retry_count, state,
           lock_loss_count
  );
endinterface
`default_nettype wire

// File: rtl/csi_rx_clk_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : csi_rx_clk_supervisor
// Brief    : CSI-2 RX clock-lane MMCM bring-up/recovery sequencer; lock-loss
//            statistics built only with CSI_CLK_SUP_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module csi_rx_clk_supervisor #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int SETTLE_CYCLES  = 256,
  parameter int BACKOFF_CYCLES = 1024,
  parameter int MAX_RETRIES    = 7
) (
  input  wire                    clock,
  input  wire                    reset_n,
  csi_rx_clk_supervisor_if.slave bus
);

  localparam int c_max_ab  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int c_max_cd  = (SETTLE_CYCLES > BACKOFF_CYCLES) ? SETTLE_CYCLES : BACKOFF_CYCLES;
  localparam int c_cnt_top = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_cnt_w   = $clog2(c_cnt_top + 1);

  typedef logic [c_cnt_w-1:0] cnt_t;

  localparam cnt_t       c_rst_last     = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t       c_timeout_last = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t       c_settle_last  = cnt_t'(SETTLE_CYCLES - 1);
  localparam cnt_t       c_backoff_last = cnt_t'(BACKOFF_CYCLES - 1);
  localparam logic [3:0] c_max_retries  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_BACKOFF   = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  state_t     r_state;
  cnt_t       r_count;
  logic       r_lock_meta;
  logic       r_lock_s;
  logic       r_phy_reset;
  logic       r_link_ready;
  logic       r_fault;
  logic       r_lock_lost;
  logic [3:0] r_retry_count;

  logic w_attempt_failed;
  logic w_lock_loss;

  // pll_lock comes from the MMCM domain; never look at it before two flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= bus.pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  assign w_attempt_failed = ((r_state == ST_WAIT_LOCK) && !r_lock_s && (r_count == c_timeout_last))
                         || ((r_state == ST_SETTLE) && !r_lock_s);
  assign w_lock_loss      = bus.enable && (r_state == ST_RUN) && !r_lock_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_phy_reset   <= 1'b1;
      r_link_ready  <= 1'b0;
      r_fault       <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_retry_count <= '0;
    end else begin
      r_lock_lost <= 1'b0;
      if (r_count != '1) r_count <= r_count + cnt_t'(1);

      if (!bus.enable) begin
        if (r_state != ST_IDLE) r_count <= '0;
        r_state       <= ST_IDLE;
        r_phy_reset   <= 1'b1;
        r_link_ready  <= 1'b0;
        r_fault       <= 1'b0;
        r_retry_count <= '0;
      end else if (w_attempt_failed) begin
        r_count     <= '0;
        r_phy_reset <= 1'b1;
        if (r_retry_count == c_max_retries) begin
          r_state <= ST_FAULT;
          r_fault <= 1'b1;
        end else begin
          r_state       <= ST_BACKOFF;
          r_retry_count <= r_retry_count + 4'd1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_retry_count <= '0;
            r_phy_reset   <= 1'b1;
            r_state       <= ST_RESET;
            r_count       <= '0;
          end
          ST_RESET: begin
            if (r_count == c_rst_last) begin
              r_state     <= ST_WAIT_LOCK;
              r_count     <= '0;
              r_phy_reset <= 1'b0;
            end
          end
          ST_WAIT_LOCK: begin
            if (r_lock_s) begin
              r_state <= ST_SETTLE;
              r_count <= '0;
            end
          end
          ST_SETTLE: begin
            if (r_count == c_settle_last) begin
              r_state       <= ST_RUN;
              r_count       <= '0;
              r_link_ready  <= 1'b1;
              r_retry_count <= '0;
            end
          end
          ST_RUN: begin
            // lock loss while running is a fresh start, not a failed attempt
            if (w_lock_loss) begin
              r_state      <= ST_RESET;
              r_count      <= '0;
              r_phy_reset  <= 1'b1;
              r_link_ready <= 1'b0;
              r_lock_lost  <= 1'b1;
            end
          end
          ST_BACKOFF: begin
            if (r_count == c_backoff_last) begin
              r_state <= ST_RESET;
              r_count <= '0;
            end
          end
          ST_FAULT: begin
            r_phy_reset  <= 1'b1;
            r_link_ready <= 1'b0;
          end
          default: begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_phy_reset <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef CSI_CLK_SUP_STATS_EN
  logic [15:0] r_lock_loss_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_loss_count <= '0;
    end else if (w_lock_loss && (r_lock_loss_count != 16'hFFFF)) begin
      r_lock_loss_count <= r_lock_loss_count + 16'd1;
    end
  end

  assign bus.lock_loss_count = r_lock_loss_count;
`else
  assign bus.lock_loss_count = 16'd0;
`endif

  assign bus.phy_reset   = r_phy_reset;
  assign bus.link_ready  = r_link_ready;
  assign bus.fault       = r_fault;
  assign bus.lock_lost   = r_lock_lost;
  assign bus.retry_count = r_retry_count;
  assign bus.state       = r_state;

endmodule
`default_nettype wire
